// File: rtl/d_stream_pkg.sv
// Shared types and defaults for the serial "d" stream receiver.
// Holds the FSM state encoding, the default width/pattern, and the bit_cnt width helper.
package d_stream_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} d_stream_state_t;

  localparam int          DEFAULT_WIDTH   = 8;
  localparam logic [31:0] DEFAULT_PATTERN = 32'h0000_00A5;

  // bit_cnt must be able to hold WIDTH itself (the "word complete" count).
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/d_stream_rx_if.sv
// Word-level valid/ready port of the d stream receiver.
// The master drives the assembled word; the slave consumes it.
interface d_stream_rx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;

  modport master (output word_out, output word_valid, input word_ready);
  modport slave  (input word_out, input word_valid, output word_ready);
endinterface

// File: rtl/d_stream_shift.sv
// Serial-to-parallel front end: MSB-first shift register and bit counter.
// done is high for the single cycle in which a full WIDTH-bit word sits in shreg.
module d_stream_shift
  import d_stream_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr,
  input  logic                      d_in,
  input  logic                      d_valid,
  output logic [WIDTH-1:0]          shreg,
  output logic [cnt_w(WIDTH)-1:0]   bit_cnt,
  output logic                      done
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  assign done = (bit_cnt == FULL);

  // A bit arriving while done starts the next word, so back-to-back words lose nothing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (d_valid) begin
      shreg   <= {shreg[WIDTH-2:0], d_in};
      bit_cnt <= done ? CW'(1) : bit_cnt + CW'(1);
    end else if (done) begin
      bit_cnt <= '0;
    end
  end

endmodule

// File: rtl/d_stream_rx.sv
// Receive end of the serial d stream: assembles words and offers them through a holding register.
// Optional feature macro D_STREAM_MATCH_EN enables the PATTERN comparator driving match.
module d_stream_rx
  import d_stream_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
`ifdef D_STREAM_MATCH_EN
  ,
  parameter logic [WIDTH-1:0] PATTERN = DEFAULT_PATTERN[WIDTH-1:0]
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    d_in,
  input  logic                    d_valid,
  d_stream_rx_if.master           word_if,
  output logic [cnt_w(WIDTH)-1:0] bit_cnt,
  output logic                    overflow,
  output logic                    match
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("d_stream_rx: WIDTH must be in 2..32");
  end

  d_stream_state_t  state;
  logic [WIDTH-1:0] shreg;
  logic             done;
  logic             load;
  logic             drain;

  d_stream_shift #(.WIDTH(WIDTH)) u_shift (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .d_in    (d_in),
    .d_valid (d_valid),
    .shreg   (shreg),
    .bit_cnt (bit_cnt),
    .done    (done)
  );

  // clr in DONE cancels the transfer outright: no load and no overflow.
  assign load  = (state == DONE) && !clr;
  assign drain = word_if.word_valid && word_if.word_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      word_if.word_out   <= '0;
      word_if.word_valid <= 1'b0;
      overflow           <= 1'b0;
`ifdef D_STREAM_MATCH_EN
      match              <= 1'b0;
`endif
    end else begin
`ifdef D_STREAM_MATCH_EN
      match <= 1'b0;
`endif
      if (clr) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE:    if (d_valid) state <= SHIFT;
          SHIFT:   if (d_valid && bit_cnt == LAST) state <= DONE;
          DONE:    state <= d_valid ? SHIFT : IDLE;
          default: state <= IDLE;
        endcase
      end

      // A slot being drained this cycle counts as free, so a full-rate consumer never drops.
      if (load) begin
        if (!word_if.word_valid || drain) begin
          word_if.word_out   <= shreg;
          word_if.word_valid <= 1'b1;
`ifdef D_STREAM_MATCH_EN
          match              <= (shreg == PATTERN);
`endif
        end else begin
          overflow <= 1'b1;
        end
      end else if (drain) begin
        word_if.word_valid <= 1'b0;
      end
    end
  end

`ifndef D_STREAM_MATCH_EN
  assign match = 1'b0;
`endif

  a_state_done : assert property (@(posedge clk) disable iff (reset) (state == DONE) == done);

endmodule

// File: tb/tb_d_stream_rx.sv
// Directed bench for d_stream_rx (WIDTH=8); expected match follows D_STREAM_MATCH_EN.
module tb_d_stream_rx;

  localparam int WIDTH = 8;
`ifdef D_STREAM_MATCH_EN
  localparam logic MATCH_ON = 1'b1;
`else
  localparam logic MATCH_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       clr;
  logic       d_in;
  logic       d_valid;
  logic [3:0] bit_cnt;
  logic       overflow;
  logic       match;

  int n_chk  = 0;
  int n_pass = 0;

  d_stream_rx_if #(.WIDTH(WIDTH)) wif ();

  d_stream_rx #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .d_in     (d_in),
    .d_valid  (d_valid),
    .word_if  (wif),
    .bit_cnt  (bit_cnt),
    .overflow (overflow),
    .match    (match)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Bits are driven on the falling edge and sampled by the DUT on the next rising edge;
  // the task returns on the falling edge after the last bit with d_valid dropped.
  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      d_in    = w[n-1-i];
      d_valid = 1'b1;
    end
    @(negedge clk);
    d_valid = 1'b0;
    d_in    = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    clr            = 1'b0;
    d_in           = 1'b0;
    d_valid        = 1'b0;
    wif.word_ready = 1'b0;

    // 1: reset held with d_valid toggling
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      d_valid = ~d_valid;
      d_in    = 1'b1;
    end
    chk("rst_bit_cnt", 32'(bit_cnt), 32'd0);
    chk("rst_word_out", 32'(wif.word_out), 32'h00);
    chk("rst_word_valid", 32'(wif.word_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    reset   = 1'b0;
    d_valid = 1'b0;
    d_in    = 1'b0;
    @(negedge clk);
    chk("rel_bit_cnt", 32'(bit_cnt), 32'd0);
    chk("rel_word_valid", 32'(wif.word_valid), 32'd0);

    // 2: single word 0xA5 with consumer ready
    wif.word_ready = 1'b1;
    send_bits(32'hA5, 8);
    chk("a5_bit_cnt_full", 32'(bit_cnt), 32'd8);
    chk("a5_not_yet_valid", 32'(wif.word_valid), 32'd0);
    @(negedge clk);
    chk("a5_valid", 32'(wif.word_valid), 32'd1);
    chk("a5_word", 32'(wif.word_out), 32'hA5);
    chk("a5_match", 32'(match), 32'(MATCH_ON));
    chk("a5_bit_cnt_idle", 32'(bit_cnt), 32'd0);
    @(negedge clk);
    chk("a5_drained", 32'(wif.word_valid), 32'd0);
    chk("a5_match_pulse_end", 32'(match), 32'd0);
    chk("a5_word_hold", 32'(wif.word_out), 32'hA5);

    // 3: back-to-back 0xF0, 0x0F
    send_bits(32'hF00F, 16);
    chk("b2b_first_word", 32'(wif.word_out), 32'hF0);
    chk("b2b_bit_cnt", 32'(bit_cnt), 32'd8);
    @(negedge clk);
    chk("b2b_second_valid", 32'(wif.word_valid), 32'd1);
    chk("b2b_second_word", 32'(wif.word_out), 32'h0F);
    chk("b2b_match", 32'(match), 32'd0);
    chk("b2b_overflow", 32'(overflow), 32'd0);
    @(negedge clk);

    // 5: clr discards a partial word, priority over d_valid
    send_bits(32'h1F, 5);
    chk("clr_pre_cnt", 32'(bit_cnt), 32'd5);
    clr     = 1'b1;
    d_valid = 1'b1;
    d_in    = 1'b1;
    @(negedge clk);
    clr     = 1'b0;
    d_valid = 1'b0;
    chk("clr_bit_cnt", 32'(bit_cnt), 32'd0);
    send_bits(32'h3C, 8);
    @(negedge clk);
    chk("clr_next_word", 32'(wif.word_out), 32'h3C);
    chk("clr_next_valid", 32'(wif.word_valid), 32'd1);
    @(negedge clk);

    // clr in DONE cancels the transfer
    send_bits(32'h77, 8);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_done_valid", 32'(wif.word_valid), 32'd0);
    chk("clr_done_word", 32'(wif.word_out), 32'h3C);
    chk("clr_done_cnt", 32'(bit_cnt), 32'd0);
    chk("clr_done_ovf", 32'(overflow), 32'd0);

    // 4: holding full, second word dropped
    wif.word_ready = 1'b0;
    send_bits(32'h11, 8);
    send_bits(32'h22, 8);
    chk("full_first_held", 32'(wif.word_out), 32'h11);
    chk("full_ovf_before", 32'(overflow), 32'd0);
    @(negedge clk);
    chk("full_ovf", 32'(overflow), 32'd1);
    chk("full_word_kept", 32'(wif.word_out), 32'h11);
    chk("full_valid_kept", 32'(wif.word_valid), 32'd1);
    chk("full_no_match", 32'(match), 32'd0);
    wif.word_ready = 1'b1;
    @(negedge clk);
    chk("full_drained", 32'(wif.word_valid), 32'd0);
    chk("full_ovf_sticky", 32'(overflow), 32'd1);
    chk("full_word_after_drain", 32'(wif.word_out), 32'h11);

    // 6: async reset in the middle of a word
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      d_in    = 1'b1;
      d_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("mid_pre_cnt", 32'(bit_cnt), 32'd4);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_cnt", 32'(bit_cnt), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    d_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("mid_no_word", 32'(wif.word_valid), 32'd0);
    chk("mid_word_zero", 32'(wif.word_out), 32'h00);
    chk("mid_idle_cnt", 32'(bit_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
